// File: rtl/dino_game_ctrl.sv
// rtl/dino_game_ctrl.sv - Dino runner game sequencer: state machine, jump physics, scroll speed, BCD score
module dino_game_ctrl #(
    parameter int JUMP_V     = 12,
    parameter int GRAVITY    = 1,
    parameter int SCORE_DIV  = 6,
    parameter int SPEED_INIT = 2,
    parameter int SPEED_MAX  = 8
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        tick,
    input  logic        jump,
    input  logic        restart,
    input  logic        collide,
    output logic [1:0]  game_state,
    output logic [7:0]  dino_y,
    output logic [3:0]  scroll_speed,
    output logic [15:0] score_bcd,
    output logic [15:0] hi_bcd
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_OVER = 2'b10;

    localparam logic [7:0] JUMP_V_C   = 8'(JUMP_V);
    localparam logic [7:0] GRAVITY_C  = 8'(GRAVITY);
    localparam logic [7:0] DIV_LAST   = 8'(SCORE_DIV - 1);
    localparam logic [3:0] SPEED_INIT_C = 4'(SPEED_INIT);
    localparam logic [3:0] SPEED_MAX_C  = 4'(SPEED_MAX);

    logic              jump_q;
    logic              jump_pend;
    logic              jump_edge;
    logic signed [7:0] vel;
    logic [7:0]        div_cnt;
    logic signed [9:0] y_sum;
    logic [15:0]       score_inc;
    logic              tens_carry;
    logic [3:0]        speed_inc;

    assign jump_edge = jump & ~jump_q;

    // Next height candidate: unsigned height plus signed velocity, wide enough to see underflow
    assign y_sum = $signed({2'b00, dino_y}) + $signed({{2{vel[7]}}, vel});

    assign speed_inc = (scroll_speed >= SPEED_MAX_C) ? SPEED_MAX_C : scroll_speed + 4'd1;

    // BCD +1 with per-digit carry; saturates at 9999, flags carry out of the tens digit
    always_comb begin
        score_inc  = score_bcd;
        tens_carry = 1'b0;
        if (score_bcd != 16'h9999) begin
            if (score_bcd[3:0] != 4'd9) begin
                score_inc[3:0] = score_bcd[3:0] + 4'd1;
            end else begin
                score_inc[3:0] = 4'd0;
                if (score_bcd[7:4] != 4'd9) begin
                    score_inc[7:4] = score_bcd[7:4] + 4'd1;
                end else begin
                    score_inc[7:4] = 4'd0;
                    tens_carry     = 1'b1;
                    if (score_bcd[11:8] != 4'd9) begin
                        score_inc[11:8] = score_bcd[11:8] + 4'd1;
                    end else begin
                        score_inc[11:8]  = 4'd0;
                        score_inc[15:12] = score_bcd[15:12] + 4'd1;
                    end
                end
            end
        end
    end

    // Jump edge detection and a one-frame pending-jump latch
    always_ff @(posedge clk) begin
        if (clr) begin
            jump_q    <= 1'b0;
            jump_pend <= 1'b0;
        end else begin
            jump_q <= jump;
            if (restart) begin
                jump_pend <= 1'b0;
            end else if (game_state != S_RUN && game_state != S_OVER) begin
                // the edge that starts a game must not also launch a jump
                jump_pend <= 1'b0;
            end else if (tick) begin
                jump_pend <= 1'b0;
            end else if (jump_edge) begin
                jump_pend <= 1'b1;
            end
        end
    end

    // Game state machine with per-frame physics, score and speed updates
    always_ff @(posedge clk) begin
        if (clr) begin
            game_state   <= S_IDLE;
            dino_y       <= 8'd0;
            vel          <= 8'sd0;
            scroll_speed <= 4'd0;
            score_bcd    <= 16'h0000;
            hi_bcd       <= 16'h0000;
            div_cnt      <= 8'd0;
        end else if (restart) begin
            game_state   <= S_IDLE;
            dino_y       <= 8'd0;
            vel          <= 8'sd0;
            scroll_speed <= 4'd0;
            score_bcd    <= 16'h0000;
            div_cnt      <= 8'd0;
        end else begin
            case (game_state)
                S_RUN: begin
                    if (tick) begin
                        if (collide) begin
                            game_state   <= S_OVER;
                            scroll_speed <= 4'd0;
                            if (score_bcd > hi_bcd) begin
                                hi_bcd <= score_bcd;
                            end
                        end else begin
                            if (dino_y == 8'd0 && vel == 8'sd0) begin
                                if (jump_pend) begin
                                    dino_y <= JUMP_V_C;
                                    vel    <= $signed(JUMP_V_C - GRAVITY_C);
                                end
                            end else if (y_sum <= 10'sd0) begin
                                dino_y <= 8'd0;
                                vel    <= 8'sd0;
                            end else begin
                                dino_y <= y_sum[7:0];
                                vel    <= vel - $signed(GRAVITY_C);
                            end

                            if (div_cnt >= DIV_LAST) begin
                                div_cnt   <= 8'd0;
                                score_bcd <= score_inc;
                                if (tens_carry) begin
                                    scroll_speed <= speed_inc;
                                end
                            end else begin
                                div_cnt <= div_cnt + 8'd1;
                            end
                        end
                    end
                end
                S_OVER: begin
                    game_state <= S_OVER;
                end
                default: begin
                    // unused encoding 11 collapses back to IDLE
                    if (jump_edge) begin
                        game_state   <= S_RUN;
                        dino_y       <= 8'd0;
                        vel          <= 8'sd0;
                        scroll_speed <= SPEED_INIT_C;
                        score_bcd    <= 16'h0000;
                        div_cnt      <= 8'd0;
                    end else begin
                        game_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dino_game_ctrl.sv
// tb/tb_dino_game_ctrl.sv - directed self-checking bench for dino_game_ctrl
module tb_dino_game_ctrl;

    logic        clk;
    logic        clr;
    logic        tick;
    logic        jump;
    logic        restart;
    logic        collide;
    logic [1:0]  game_state;
    logic [7:0]  dino_y;
    logic [3:0]  scroll_speed;
    logic [15:0] score_bcd;
    logic [15:0] hi_bcd;

    int checks;
    int failures;

    logic [7:0] exp_y [25];

    dino_game_ctrl dut (
        .clk          (clk),
        .clr          (clr),
        .tick         (tick),
        .jump         (jump),
        .restart      (restart),
        .collide      (collide),
        .game_state   (game_state),
        .dino_y       (dino_y),
        .scroll_speed (scroll_speed),
        .score_bcd    (score_bcd),
        .hi_bcd       (hi_bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    task automatic jump_pulse();
        jump = 1'b1;
        step();
        jump = 1'b0;
        step();
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_y = '{8'd12, 8'd23, 8'd33, 8'd42, 8'd50, 8'd57, 8'd63, 8'd68, 8'd72, 8'd75,
                  8'd77, 8'd78, 8'd78, 8'd77, 8'd75, 8'd72, 8'd68, 8'd63, 8'd57, 8'd50,
                  8'd42, 8'd33, 8'd23, 8'd12, 8'd0};
        clr = 1'b1; tick = 1'b0; jump = 1'b0; restart = 1'b0; collide = 1'b0;

        // T1 reset
        step();
        step();
        clr = 1'b0;
        check("t1_state", 16'(game_state), 16'h0);
        check("t1_y", 16'(dino_y), 16'h0);
        check("t1_speed", 16'(scroll_speed), 16'h0);
        check("t1_score", score_bcd, 16'h0000);
        check("t1_hi", hi_bcd, 16'h0000);

        // T2 start game, held jump does not launch
        step();
        jump = 1'b1;
        step();
        check("t2_state", 16'(game_state), 16'h1);
        check("t2_speed", 16'(scroll_speed), 16'h2);
        check("t2_score", score_bcd, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            ticks(1);
            step();
            check("t2_y_held", 16'(dino_y), 16'h0);
        end
        jump = 1'b0;
        step();

        // T3 jump arc
        do_restart();
        jump_pulse();
        check("t3_state", 16'(game_state), 16'h1);
        jump_pulse();
        for (int i = 0; i < 25; i++) begin
            ticks(1);
            check($sformatf("t3_y%0d", i + 1), 16'(dino_y), 16'(exp_y[i]));
        end

        // T4 scoring, speed steps and saturation
        do_restart();
        jump_pulse();
        ticks(600);
        check("t4_score100", score_bcd, 16'h0100);
        check("t4_speed3", 16'(scroll_speed), 16'h3);
        ticks(59994 - 600);
        check("t4_score9999", score_bcd, 16'h9999);
        check("t4_speed8", 16'(scroll_speed), 16'h8);
        ticks(6);
        check("t4_sat", score_bcd, 16'h9999);
        check("t4_speed_sat", 16'(scroll_speed), 16'h8);

        // T5 collision while airborne with a pending jump
        do_restart();
        check("t5_hi_kept", hi_bcd, 16'h0000);
        jump_pulse();
        ticks(252);
        check("t5_score42", score_bcd, 16'h0042);
        jump_pulse();
        ticks(1);
        check("t5_y_launch", 16'(dino_y), 16'd12);
        jump_pulse();
        collide = 1'b1;
        ticks(1);
        collide = 1'b0;
        check("t5_state_over", 16'(game_state), 16'h2);
        check("t5_hi", hi_bcd, 16'h0042);
        check("t5_speed0", 16'(scroll_speed), 16'h0);
        check("t5_y_frozen", 16'(dino_y), 16'd12);
        check("t5_score_kept", score_bcd, 16'h0042);
        jump_pulse();
        ticks(3);
        check("t5_over_jump", 16'(game_state), 16'h2);
        check("t5_over_y", 16'(dino_y), 16'd12);

        // T6 restart keeps hi; lower game leaves hi; clr clears hi
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("t6_state", 16'(game_state), 16'h0);
        check("t6_score", score_bcd, 16'h0000);
        check("t6_y", 16'(dino_y), 16'h0);
        check("t6_hi", hi_bcd, 16'h0042);
        step();
        jump_pulse();
        ticks(180);
        check("t6_score30", score_bcd, 16'h0030);
        collide = 1'b1;
        ticks(1);
        collide = 1'b0;
        check("t6_over", 16'(game_state), 16'h2);
        check("t6_hi_stays", hi_bcd, 16'h0042);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("t6_clr_hi", hi_bcd, 16'h0000);
        check("t6_clr_state", 16'(game_state), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
